// File: rtl/snake_engine.sv
// Snake game engine: circular body queue, step timer, collision and food over a row-bitmap RAM.
// Optional SNAKE_WALL_KILL_EN: leaving the field ends the game instead of wrapping.
module snake_engine #(
    parameter int         X_W        = 6,
    parameter int         Y_W        = 6,
    parameter int         X_MAX      = 59,
    parameter int         Y_MAX      = 33,
    parameter int         MAX_LEN    = 64,
    parameter int         INIT_LEN   = 3,
    parameter int         STEP_DELAY = 4194303,
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 direction,
    input  logic                       pause,
    input  logic [X_MAX:0]             read_data,
    output logic [Y_W-1:0]             rw_address,
    output logic                       wr_en,
    output logic [X_MAX:0]             write_data,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       game_over,
    output logic                       busy
);
    localparam int ROW_W = X_MAX + 1;
    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STEP_DELAY + 1);
    localparam int C_W   = X_W + Y_W;
    localparam logic [ROW_W-1:0] ONE = 1;
`ifdef SNAKE_WALL_KILL_EN
    localparam bit WALL_KILL = 1'b1;
`else
    localparam bit WALL_KILL = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_CLEAR, S_INIT, S_FOOD, S_FOOD_RD, S_FOOD_WR, S_IDLE,
        S_STEP, S_HEAD_RD, S_HEAD_WR, S_TAIL_RD, S_TAIL_WR, S_OVER
    } state_t;

    state_t           r_state;
    logic             r_live;
    logic [Y_W-1:0]   r_addr;
    logic [Y_W-1:0]   r_row;
    logic             r_wr_en;
    logic [ROW_W-1:0] r_wdata;
    logic [LEN_W-1:0] r_len;
    logic             r_over;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rd;
    logic [1:0]       r_dir;
    logic [X_W-1:0]   r_hx, r_fx, r_tx;
    logic [Y_W-1:0]   r_hy, r_fy, r_ty;
    logic             r_eaten;
    logic [11:0]      r_lfsr;
    logic [C_W-1:0]   r_q [MAX_LEN];
    logic [PTR_W-1:0] r_wp, r_rp;

    logic [1:0]       w_dir;
    logic [X_W-1:0]   w_nx, w_cx;
    logic [Y_W-1:0]   w_ny, w_cy;
    logic             w_wall, w_cand_ok, w_rd_done, w_fb;
    logic [ROW_W-1:0] w_hbit, w_fbit, w_tbit, w_init_row;

    // A request for the opposite direction keeps the current heading
    assign w_dir      = ((direction ^ r_dir) == 2'b10) ? r_dir : direction;
    assign w_cx       = r_lfsr[X_W-1:0];
    assign w_cy       = r_lfsr[X_W +: Y_W];
    assign w_cand_ok  = (w_cx <= X_W'(X_MAX)) && (w_cy <= Y_W'(Y_MAX));
    assign w_rd_done  = (r_rd == 2'd2);
    assign w_fb       = r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0];
    assign w_hbit     = ONE << r_hx;
    assign w_fbit     = ONE << r_fx;
    assign w_tbit     = ONE << r_tx;
    assign w_init_row = ~({ROW_W{1'b1}} << INIT_LEN);

    always_comb begin
        w_nx   = r_hx;
        w_ny   = r_hy;
        w_wall = 1'b0;
        unique case (w_dir)
            2'b00: begin
                w_wall = (r_hx == X_W'(X_MAX));
                w_nx   = (r_hx == X_W'(X_MAX)) ? '0 : r_hx + 1'b1;
            end
            2'b01: begin
                w_wall = (r_hy == Y_W'(Y_MAX));
                w_ny   = (r_hy == Y_W'(Y_MAX)) ? '0 : r_hy + 1'b1;
            end
            2'b10: begin
                w_wall = (r_hx == '0);
                w_nx   = (r_hx == '0) ? X_W'(X_MAX) : r_hx - 1'b1;
            end
            default: begin
                w_wall = (r_hy == '0);
                w_ny   = (r_hy == '0) ? Y_W'(Y_MAX) : r_hy - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            for (int i = 0; i < INIT_LEN; i++)
                r_q[i] <= {{Y_W{1'b0}}, X_W'(i)};
        end else if (r_state == S_HEAD_WR) begin
            r_q[r_wp] <= {r_hy, r_hx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_row   <= '0;
            r_wr_en <= 1'b0;
            r_wdata <= '0;
            r_len   <= LEN_W'(INIT_LEN);
            r_over  <= 1'b0;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_dir   <= 2'b00;
            r_hx    <= '0;
            r_hy    <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_eaten <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            r_live  <= 1'b1;
            r_lfsr  <= {r_lfsr[10:0], w_fb};
            r_wr_en <= 1'b0;
            r_rd    <= r_rd + 2'd1;
            unique case (r_state)
                S_CLEAR: begin
                    r_wr_en <= 1'b1;
                    r_wdata <= '0;
                    r_addr  <= r_row;
                    r_row   <= r_row + 1'b1;
                    if (r_row == Y_W'(Y_MAX)) r_state <= S_INIT;
                end
                S_INIT: begin
                    r_wr_en <= 1'b1;
                    r_addr  <= '0;
                    r_wdata <= w_init_row;
                    r_hx    <= X_W'(INIT_LEN - 1);
                    r_hy    <= '0;
                    r_dir   <= 2'b00;
                    r_wp    <= PTR_W'(INIT_LEN);
                    r_rp    <= '0;
                    r_state <= S_FOOD;
                end
                S_FOOD: begin
                    if (w_cand_ok) begin
                        r_fx    <= w_cx;
                        r_fy    <= w_cy;
                        r_addr  <= w_cy;
                        r_rd    <= '0;
                        r_state <= S_FOOD_RD;
                    end
                end
                S_FOOD_RD: begin
                    if (w_rd_done) begin
                        if (|(read_data & w_fbit)) begin
                            r_state <= S_FOOD;
                        end else begin
                            r_wr_en <= 1'b1;
                            r_wdata <= read_data | w_fbit;
                            r_state <= S_FOOD_WR;
                        end
                    end
                end
                S_FOOD_WR: r_state <= S_IDLE;
                S_IDLE: begin
                    if (!pause) begin
                        if (r_cnt == CNT_W'(STEP_DELAY)) begin
                            r_cnt   <= '0;
                            r_state <= S_STEP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    // Tail is captured before the push can overwrite it in a full queue
                    r_dir   <= w_dir;
                    r_hx    <= w_nx;
                    r_hy    <= w_ny;
                    r_eaten <= (w_nx == r_fx) && (w_ny == r_fy);
                    r_tx    <= r_q[r_rp][X_W-1:0];
                    r_ty    <= r_q[r_rp][C_W-1:X_W];
                    r_addr  <= w_ny;
                    r_rd    <= '0;
                    r_state <= S_HEAD_RD;
                    if (WALL_KILL && w_wall) begin
                        r_over  <= 1'b1;
                        r_state <= S_OVER;
                    end
                end
                S_HEAD_RD: begin
                    if (w_rd_done) begin
                        if (|(read_data & w_hbit) && !r_eaten) begin
                            r_over  <= 1'b1;
                            r_state <= S_OVER;
                        end else begin
                            r_wr_en <= 1'b1;
                            r_wdata <= read_data | w_hbit;
                            r_state <= S_HEAD_WR;
                        end
                    end
                end
                S_HEAD_WR: begin
                    r_wp <= r_wp + 1'b1;
                    if (r_eaten && (r_len < LEN_W'(MAX_LEN))) begin
                        r_len   <= r_len + 1'b1;
                        r_state <= S_FOOD;
                    end else begin
                        r_addr  <= r_ty;
                        r_rd    <= '0;
                        r_state <= S_TAIL_RD;
                    end
                end
                S_TAIL_RD: begin
                    if (w_rd_done) begin
                        r_wr_en <= 1'b1;
                        r_wdata <= read_data & ~w_tbit;
                        r_state <= S_TAIL_WR;
                    end
                end
                S_TAIL_WR: begin
                    r_rp    <= r_rp + 1'b1;
                    r_state <= r_eaten ? S_FOOD : S_IDLE;
                end
                S_OVER: r_state <= S_OVER;
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign rw_address = r_addr;
    assign wr_en      = r_wr_en;
    assign write_data = r_wdata;
    assign length     = r_len;
    assign game_over  = r_over;
    assign busy       = r_live && (r_state != S_IDLE) && (r_state != S_OVER);

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: RAM model, body model and a per-step scoreboard.
module tb_snake_engine;
    localparam int XM = 59;
    localparam int YM = 33;
    localparam int SD = 8;
`ifdef SNAKE_WALL_KILL_EN
    localparam bit WALL_KILL = 1'b1;
`else
    localparam bit WALL_KILL = 1'b0;
`endif

    typedef struct {int x; int y;} pt_t;
    typedef struct {
        int hx; int hy; bit clr; int tx; int ty; int len; bit over; int nwr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  direction = 2'b00;
    logic        pause = 1'b0;
    logic [59:0] read_data;
    logic [5:0]  rw_address;
    logic        wr_en;
    logic [59:0] write_data;
    logic [6:0]  length;
    logic        game_over;
    logic        busy;

    logic [59:0] mem [0:63];
    logic [59:0] p1;
    int          wr_cnt = 0;
    int          step_w0;
    int          errors = 0;
    int          checks = 0;
    int          cur_dir = 0;
    pt_t         body[$];
    exp_t        sb[$];

    always #5 clk = ~clk;

    snake_engine #(.STEP_DELAY(SD)) dut (
        .clk(clk), .rst(rst), .direction(direction), .pause(pause),
        .read_data(read_data), .rw_address(rw_address), .wr_en(wr_en),
        .write_data(write_data), .length(length), .game_over(game_over),
        .busy(busy)
    );

    // Frame RAM: write on wr_en, read data two clocks after the address
    always @(posedge clk) begin
        if (wr_en) begin
            mem[rw_address] <= write_data;
            wr_cnt <= wr_cnt + 1;
        end
        p1 <= mem[rw_address];
        read_data <= p1;
    end

    function automatic bit in_body(int x, int y);
        foreach (body[i]) if (body[i].x == x && body[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count_food(output int fx, output int fy);
        int n = 0;
        fx = -1;
        fy = -1;
        for (int y = 0; y <= YM; y++)
            for (int x = 0; x <= XM; x++)
                if (mem[y][x] === 1'b1 && !in_body(x, y)) begin
                    n++;
                    fx = x;
                    fy = y;
                end
        return n;
    endfunction

    task automatic wait_busy(input logic lvl, input int lim, input string nm);
        int n = 0;
        while (busy !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== lvl) begin
            errors++;
            $display("FAIL %s: busy=%b want %b after %0d clk", nm, busy, lvl, n);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        int fx, fy, nf;
        e = sb.pop_front();
        checks++;
        if (length !== 7'(e.len)) begin
            errors++;
            $display("FAIL step_len: got %0d want %0d", length, e.len);
        end
        checks++;
        if (game_over !== e.over) begin
            errors++;
            $display("FAIL step_over: got %b want %b", game_over, e.over);
        end
        checks++;
        if (wr_cnt - step_w0 != e.nwr) begin
            errors++;
            $display("FAIL step_writes: got %0d want %0d", wr_cnt - step_w0, e.nwr);
        end
        if (!e.over) begin
            checks++;
            if (mem[e.hy][e.hx] !== 1'b1) begin
                errors++;
                $display("FAIL head_bit (%0d,%0d): got %b want 1", e.hx, e.hy, mem[e.hy][e.hx]);
            end
            if (e.clr) begin
                checks++;
                if (mem[e.ty][e.tx] !== 1'b0) begin
                    errors++;
                    $display("FAIL tail_bit (%0d,%0d): got %b want 0", e.tx, e.ty, mem[e.ty][e.tx]);
                end
            end
            nf = count_food(fx, fy);
            checks++;
            if (nf != 1) begin
                errors++;
                $display("FAIL food_count: got %0d want 1", nf);
            end
        end
    endtask

    task automatic do_step(input logic [1:0] d);
        exp_t e;
        pt_t  h, p;
        int   nd, nx, ny, fx, fy;
        bit   wall, eaten;
        nd = ((int'(d) ^ cur_dir) == 2) ? cur_dir : int'(d);
        h  = body[$];
        nx = h.x;
        ny = h.y;
        wall = 1'b0;
        case (nd)
            0: begin wall = (h.x == XM); nx = wall ? 0 : h.x + 1; end
            1: begin wall = (h.y == YM); ny = wall ? 0 : h.y + 1; end
            2: begin wall = (h.x == 0); nx = wall ? XM : h.x - 1; end
            default: begin wall = (h.y == 0); ny = wall ? YM : h.y - 1; end
        endcase
        void'(count_food(fx, fy));
        eaten  = (nx == fx && ny == fy);
        e.over = (WALL_KILL && wall) || (mem[ny][nx] === 1'b1 && !eaten);
        e.hx   = nx;
        e.hy   = ny;
        e.clr  = !eaten;
        e.tx   = body[0].x;
        e.ty   = body[0].y;
        e.len  = body.size() + ((eaten && !e.over) ? 1 : 0);
        e.nwr  = e.over ? 0 : 2;
        sb.push_back(e);
        if (!e.over) begin
            p.x = nx;
            p.y = ny;
            body.push_back(p);
            if (!eaten) void'(body.pop_front());
            cur_dir = nd;
        end
        direction = d;
        step_w0 = wr_cnt;
        wait_busy(1'b1, 200, "step_start");
        wait_busy(1'b0, 3000, "step_done");
        sb_compare();
    endtask

    task automatic test_reset();
        pt_t p;
        int  fx, fy, nf, bits;
        @(negedge clk);
        rst = 1'b0;
        for (int y = 0; y < 64; y++) mem[y] = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: wr_en=%b busy=%b over=%b want 0", wr_en, busy, game_over);
        end
        checks++;
        if (length !== 7'd3) begin
            errors++;
            $display("FAIL reset_len: got %0d want 3", length);
        end
        checks++;
        if (rw_address !== 6'd0 || write_data !== 60'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0d data=%h want 0", rw_address, write_data);
        end
        step_w0 = wr_cnt;
        rst = 1'b1;
        wait_busy(1'b1, 20, "init_start");
        wait_busy(1'b0, 3000, "init_done");
        for (int i = 0; i < 3; i++) begin
            p.x = i;
            p.y = 0;
            body.push_back(p);
        end
        checks++;
        if (wr_cnt - step_w0 != YM + 3) begin
            errors++;
            $display("FAIL init_writes: got %0d want %0d", wr_cnt - step_w0, YM + 3);
        end
        checks++;
        if (mem[0][2:0] !== 3'b111) begin
            errors++;
            $display("FAIL init_row0: got %b want 111", mem[0][2:0]);
        end
        bits = 0;
        for (int y = 0; y <= YM; y++) bits += $countones(mem[y]);
        checks++;
        if (bits != 4) begin
            errors++;
            $display("FAIL init_bits: got %0d want 4", bits);
        end
        nf = count_food(fx, fy);
        checks++;
        if (nf != 1) begin
            errors++;
            $display("FAIL init_food: got %0d want 1", nf);
        end
    endtask

    task automatic test_straight();
        for (int i = 0; i < 4; i++) do_step(2'b00);
    endtask

    task automatic test_reversal();
        pt_t h;
        h = body[$];
        do_step(2'b10);
        checks++;
        if (mem[h.y][(h.x + 1) % (XM + 1)] !== 1'b1) begin
            errors++;
            $display("FAIL reversal: cell right of head got %b want 1", mem[h.y][(h.x + 1) % (XM + 1)]);
        end
        do_step(2'b10);
    endtask

    task automatic test_pause();
        int  w0;
        bit  seen;
        direction = 2'b00;
        pause = 1'b1;
        w0 = wr_cnt;
        seen = 1'b0;
        repeat (100 * (SD + 20)) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL pause_writes: got %0d want 0", wr_cnt - w0);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL pause_busy: got 1 want 0");
        end
        pause = 1'b0;
        do_step(2'b00);
    endtask

    task automatic test_eat(input int target);
        int fx, fy, n = 0;
        while (body.size() < target && n < 300 && game_over !== 1'b1) begin
            void'(count_food(fx, fy));
            do_step((body[$].y != fy) ? 2'b01 : 2'b00);
            n++;
        end
        checks++;
        if (length !== 7'(target)) begin
            errors++;
            $display("FAIL eat_len: got %0d want %0d", length, target);
        end
    endtask

    task automatic test_wrap();
        int y, w0, n = 0;
        while (body[$].x != XM && n < 80 && game_over !== 1'b1) begin
            do_step(2'b00);
            n++;
        end
        y = body[$].y;
        do_step(2'b00);
        if (WALL_KILL) begin
            w0 = wr_cnt;
            repeat (200) @(negedge clk);
            checks++;
            if (game_over !== 1'b1 || wr_cnt != w0) begin
                errors++;
                $display("FAIL wall_kill: over=%b writes=%0d want 1/0", game_over, wr_cnt - w0);
            end
        end else begin
            checks++;
            if (mem[y][0] !== 1'b1 || game_over !== 1'b0) begin
                errors++;
                $display("FAIL wrap: cell(0,%0d)=%b over=%b want 1/0", y, mem[y][0], game_over);
            end
        end
    endtask

    task automatic test_collision();
        int w0;
        for (int i = 0; i < 5; i++) do_step(2'b00);
        do_step(2'b01);
        do_step(2'b10);
        do_step(2'b11);
        w0 = wr_cnt;
        repeat (100) @(negedge clk);
        checks++;
        if (game_over !== 1'b1 || wr_cnt != w0) begin
            errors++;
            $display("FAIL collision: over=%b writes=%0d want 1/0", game_over, wr_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_reversal();
        test_pause();
        if (WALL_KILL) begin
            test_wrap();
        end else begin
            test_eat(body.size() + 1);
            test_eat(5);
            test_wrap();
            test_collision();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
